extern_usart_tx: RTL and testbench

Memory-mapped asynchronous serial transmitter that responds to the midrange core's external peripheral bus. It is a bus target for register writes from the core and serialises bytes onto a single `tx` line, 8N1 or 9N1 format, with its own baud-rate generator. It returns read data for its registers and drives a transmit-interrupt flag that the top level routes to PIR1.

---
 rtl/extern_usart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_extern_usart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/extern_usart_tx.sv
// Memory-mapped async serial transmitter (TXREG/TXSTA/SPBRG) with its own baud generator.
// Define EXTERN_USART_TX9_EN to implement TX9/TX9D and the ninth-bit frame slot.
module extern_usart_tx #(
    parameter logic [8:0] TXREG_ADDR = 9'h019,
    parameter logic [8:0] TXSTA_ADDR = 9'h098,
    parameter logic [8:0] SPBRG_ADDR = 9'h099
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    output logic       tx,
    output logic       txif,
    output logic       trmt
);

    localparam int unsigned PRE_W = 6;
    localparam int unsigned BRG_W = 8;
    localparam int unsigned BIT_W = 3;

    `ifdef EXTERN_USART_TX9_EN
    typedef enum logic [2:0] {IDLE, START, DATA, BIT9, STOP} state_t;
    `else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    `endif

    state_t             state;
    logic               txen;
    logic               brgh;
    logic               tx9;
    logic               tx9d;
    logic [BRG_W-1:0]   spbrg;
    logic [7:0]         tx_buf;
    logic [7:0]         tsr;
    logic [BIT_W-1:0]   bit_cnt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [BRG_W-1:0]   brg_cnt;
    logic [PRE_W-1:0]   pre_max_c;
    logic               tick_c;
    logic               load_c;
    logic               flush_c;
    logic               wr_txreg_c;
    logic               wr_txsta_c;
    logic               wr_spbrg_c;

    assign wr_txreg_c = extern_peripherals_wr_en && (extern_peripherals_addr == TXREG_ADDR);
    assign wr_txsta_c = extern_peripherals_wr_en && (extern_peripherals_addr == TXSTA_ADDR);
    assign wr_spbrg_c = extern_peripherals_wr_en && (extern_peripherals_addr == SPBRG_ADDR);

    // txif doubles as the buffer-empty flag
    assign pre_max_c = brgh ? PRE_W'(15) : PRE_W'(63);
    assign tick_c    = (pre_cnt == '0) && (brg_cnt == '0);
    assign load_c    = txen && !txif && ((state == IDLE) || ((state == STOP) && tick_c));
    assign flush_c   = !txen && (state != IDLE);

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            txen  <= 1'b0;
            brgh  <= 1'b0;
            spbrg <= '0;
        end else begin
            if (wr_txsta_c) begin
                txen <= extern_peripherals_data_in[5];
                brgh <= extern_peripherals_data_in[2];
            end
            if (wr_spbrg_c)
                spbrg <= extern_peripherals_data_in;
        end
    end

    `ifdef EXTERN_USART_TX9_EN
    logic tsr9d;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx9  <= 1'b0;
            tx9d <= 1'b0;
        end else if (wr_txsta_c) begin
            tx9  <= extern_peripherals_data_in[6];
            tx9d <= extern_peripherals_data_in[0];
        end
    end
    `else
    assign tx9  = 1'b0;
    assign tx9d = 1'b0;
    `endif

    // Baud generator: prescaler wraps feed the SPBRG down-counter; both restart on TSR load
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= PRE_W'(63);
            brg_cnt <= '0;
        end else if (load_c) begin
            pre_cnt <= pre_max_c;
            brg_cnt <= spbrg;
        end else if (pre_cnt == '0) begin
            pre_cnt <= pre_max_c;
            brg_cnt <= (brg_cnt == '0) ? spbrg : brg_cnt - BRG_W'(1);
        end else begin
            pre_cnt <= pre_cnt - PRE_W'(1);
        end
    end

    // Transmit FSM, buffer and output flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            txif    <= 1'b1;
            trmt    <= 1'b1;
            tx_buf  <= '0;
            tsr     <= '0;
            bit_cnt <= '0;
            `ifdef EXTERN_USART_TX9_EN
            tsr9d   <= 1'b0;
            `endif
        end else begin
            // A TXREG write beats the buffer clear from a same-cycle load or flush
            if (wr_txreg_c) begin
                tx_buf <= extern_peripherals_data_in;
                txif   <= 1'b0;
            end else if (load_c || flush_c) begin
                txif   <= 1'b1;
            end

            if (flush_c) begin
                state <= IDLE;
                tx    <= 1'b1;
                trmt  <= 1'b1;
            end else if (load_c) begin
                state <= START;
                tx    <= 1'b0;
                trmt  <= 1'b0;
                tsr   <= tx_buf;
                `ifdef EXTERN_USART_TX9_EN
                tsr9d <= tx9d;
                `endif
            end else if (tick_c) begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        state   <= DATA;
                        tx      <= tsr[0];
                        tsr     <= {1'b0, tsr[7:1]};
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == BIT_W'(7)) begin
                            `ifdef EXTERN_USART_TX9_EN
                            if (tx9) begin
                                state <= BIT9;
                                tx    <= tsr9d;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                            `else
                            state <= STOP;
                            tx    <= 1'b1;
                            `endif
                        end else begin
                            tx      <= tsr[0];
                            tsr     <= {1'b0, tsr[7:1]};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    `ifdef EXTERN_USART_TX9_EN
                    BIT9: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    `endif
                    STOP: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        trmt  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        trmt  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Read mux; unmapped and write-only addresses return zero
    always_comb begin
        extern_peripherals_data_out = 8'h00;
        if (extern_peripherals_addr == TXSTA_ADDR)
            extern_peripherals_data_out = {1'b0, tx9, txen, 2'b00, brgh, trmt, tx9d};
        else if (extern_peripherals_addr == SPBRG_ADDR)
            extern_peripherals_data_out = spbrg;
    end

endmodule

// File: tb/tb_extern_usart_tx.sv
// Self-checking bench for extern_usart_tx: directed cases plus randomized frames
// checked against a bit-list frame model derived from the byte and baud settings.
module tb_extern_usart_tx;

    localparam logic [8:0] TXREG = 9'h019;
    localparam logic [8:0] TXSTA = 9'h098;
    localparam logic [8:0] SPBRG = 9'h099;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       wr_en;
    logic       tx;
    logic       txif;
    logic       trmt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    extern_usart_tx dut (
        .clk                         (clk),
        .rst                         (rst),
        .extern_peripherals_addr     (addr),
        .extern_peripherals_data_in  (din),
        .extern_peripherals_wr_en    (wr_en),
        .extern_peripherals_data_out (dout),
        .tx                          (tx),
        .txif                        (txif),
        .trmt                        (trmt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        din   = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [8:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    // Waits (bounded) for the first sample point with tx low
    task automatic wait_start(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx !== 1'b0 && k < 4000);
        check(tag, tx, 0);
    endtask

    // Expected line level for frame slot k: start, 8 data LSB first, optional 9th, stop
    function automatic logic exp_bit(input logic [7:0] b, input int k, input bit b9, input int nb);
        if (k == 0)      return 1'b0;
        if (k == nb - 1) return 1'b1;
        if (k <= 8)      return b[k-1];
        return b9;
    endfunction

    // Called at the first sample of a start bit; checks every slot lasts exactly T clocks
    task automatic check_frame(input string tag, input logic [7:0] b, input int t, input bit nine,
                               input bit b9, input bit last, input bit do_wr, input int wr_n,
                               input logic [7:0] wr_b);
        int nb = nine ? 11 : 10;
        int good[11];
        int trmt_hi = 0;
        foreach (good[i]) good[i] = 0;
        for (int n = 0; n < nb * t; n++) begin
            if (n > 0) @(negedge clk);
            if (do_wr && n == wr_n) begin
                addr  = TXREG;
                din   = wr_b;
                wr_en = 1'b1;
            end
            if (do_wr && n == wr_n + 1) begin
                wr_en = 1'b0;
                check({tag, "_txif_drop"}, txif, 0);
            end
            if (tx === exp_bit(b, n / t, b9, nb)) good[n/t]++;
            if (trmt !== 1'b0) trmt_hi++;
        end
        for (int k = 0; k < nb; k++)
            check($sformatf("%s_slot%0d", tag, k), good[k], t);
        check({tag, "_trmt_busy"}, trmt_hi, 0);
        @(negedge clk);
        if (last) begin
            check({tag, "_trmt_end"}, trmt, 1);
            check({tag, "_idle_tx"}, tx, 1);
        end else begin
            check({tag, "_b2b_start"}, tx, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1;
        logic [7:0] b2;
        int         lows;
        int         spb;
        int         hs;
        int         t;
        bit         two;

        rst   = 1'b1;
        wr_en = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_txif", txif, 1);
        check("rst_trmt", trmt, 1);
        check_read("rst_txsta", TXSTA, 8'h02);
        check_read("rst_spbrg", SPBRG, 8'h00);
        check_read("rst_txreg", TXREG, 8'h00);
        check_read("rst_unmapped", 9'h020, 8'h00);
        rst = 1'b0;

        // TRMT is read-only; optional bits depend on the build
        reg_write(TXSTA, 8'hFF);
        `ifdef EXTERN_USART_TX9_EN
        check_read("txsta_ff", TXSTA, 8'h67);
        `else
        check_read("txsta_ff", TXSTA, 8'h26);
        `endif
        reg_write(SPBRG, 8'h00);
        reg_write(TXSTA, 8'h24);
        check_read("txsta_cfg", TXSTA, 8'h26);

        // Single frame 0x55 with write latency checks
        reg_write(TXREG, 8'h55);
        check("lat_txif_clr", txif, 0);
        @(negedge clk);
        check("lat_tx_pre", tx, 1);
        @(negedge clk);
        check("lat_txif_set", txif, 1);
        check("lat_trmt_clr", trmt, 0);
        check_frame("f55", 8'h55, 16, 0, 0, 1, 0, 0, 8'h00);

        // Back-to-back: second byte written during the first start bit
        reg_write(TXREG, 8'hA3);
        @(negedge clk);
        @(negedge clk);
        check_frame("b2b_a3", 8'hA3, 16, 0, 0, 0, 1, 3, 8'h0F);
        check_frame("b2b_0f", 8'h0F, 16, 0, 0, 1, 0, 0, 8'h00);

        // Write coinciding with the TSR load: old byte goes out, new byte stays buffered
        reg_write(TXREG, 8'h3A);
        reg_write(TXREG, 8'hC5);
        @(negedge clk);
        check("coinc_txif", txif, 0);
        check_frame("coinc_3a", 8'h3A, 16, 0, 0, 0, 0, 0, 8'h00);
        check_frame("coinc_c5", 8'hC5, 16, 0, 0, 1, 0, 0, 8'h00);

        // Slow baud: SPBRG=2, BRGH=0 gives 192 clk per bit
        reg_write(SPBRG, 8'h02);
        reg_write(TXSTA, 8'h20);
        reg_write(TXREG, 8'h3C);
        wait_start("slow_start");
        check_frame("slow", 8'h3C, 192, 0, 0, 1, 0, 0, 8'h00);

        // Byte held while disabled, sent once enabled
        reg_write(SPBRG, 8'h00);
        reg_write(TXSTA, 8'h04);
        reg_write(TXREG, 8'hC6);
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("held_tx_quiet", lows, 0);
        check("held_txif", txif, 0);
        reg_write(TXSTA, 8'h24);
        wait_start("held_start");
        check_frame("held", 8'hC6, 16, 0, 0, 1, 0, 0, 8'h00);

        // TXEN cleared mid-DATA with a byte buffered: frame aborted, buffer flushed
        reg_write(TXREG, 8'hFF);
        wait_start("abort_start");
        repeat (5) @(negedge clk);
        reg_write(TXREG, 8'h81);
        check("abort_buf_full", txif, 0);
        repeat (40) @(negedge clk);
        reg_write(TXSTA, 8'h04);
        @(negedge clk);
        check("abort_pre_trmt", trmt, 0);
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_trmt", trmt, 1);
        check("abort_txif", txif, 1);
        reg_write(TXSTA, 8'h24);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || trmt !== 1'b1) lows++;
        end
        check("abort_no_resend", lows, 0);

        `ifdef EXTERN_USART_TX9_EN
        // Nine-bit frame: eight zeros, TX9D=1, stop; 176 clk total
        reg_write(TXSTA, 8'h65);
        check_read("tx9_txsta", TXSTA, 8'h67);
        reg_write(TXREG, 8'h00);
        wait_start("tx9_start");
        check_frame("tx9", 8'h00, 16, 1, 1, 1, 0, 0, 8'h00);
        reg_write(TXSTA, 8'h24);
        `endif

        // Randomized frames and baud settings, optionally back-to-back
        for (int i = 0; i < 6; i++) begin
            spb = $urandom_range(0, 2);
            hs  = $urandom_range(0, 1);
            b1  = 8'($urandom);
            b2  = 8'($urandom);
            two = 1'($urandom_range(0, 1));
            t   = (spb + 1) * (hs != 0 ? 16 : 64);
            reg_write(SPBRG, 8'(spb));
            reg_write(TXSTA, {2'b00, 1'b1, 2'b00, 1'(hs), 2'b00});
            reg_write(TXREG, b1);
            wait_start($sformatf("rnd%0d_start", i));
            check_frame($sformatf("rnd%0d_a", i), b1, t, 0, 0, !two, two,
                        $urandom_range(1, 5 * t), b2);
            if (two)
                check_frame($sformatf("rnd%0d_b", i), b2, t, 0, 0, 1, 0, 0, 8'h00);
        end

        // Reset in the middle of a frame
        reg_write(SPBRG, 8'h01);
        reg_write(TXSTA, 8'h24);
        reg_write(TXREG, 8'h00);
        wait_start("mrst_start");
        repeat (40) @(negedge clk);
        check("mrst_pre_tx", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_tx", tx, 1);
        check("mrst_txif", txif, 1);
        check("mrst_trmt", trmt, 1);
        check_read("mrst_txsta", TXSTA, 8'h02);
        check_read("mrst_spbrg", SPBRG, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
